bcrypt_core_output: RTL and testbench

- Core-side transmitter for the arbiter's 1-bit result bus.
- A bcrypt core writes its 16x16-bit result packet into this block: IDs, pkt_id, encryption words, padding.
- The arbiter sees the block's `empty` flag and pulses `rd_en`. The block then emits a 1-bit header followed by the packet serially, one bit per cycle.
- Two ping-pong pages let the core fill the next result while the previous one is shifting out.

---
 rtl/bcrypt_core_output.sv | 144 ++++++++++++++
 tb/tb_bcrypt_core_output.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcrypt_core_output.sv
// Core-side result transmitter: two ping-pong 16x16 pages written in parallel by a
// bcrypt core, shifted out to the arbiter as a 1-bit header followed by 256 data bits.
module bcrypt_core_output #(
  parameter int PKT_NUM_WORDS = 16,
  parameter int WORD_WIDTH    = 16,
  parameter int START_DELAY   = 2
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic [3:0]            wr_addr,
  input  logic                  wr_en,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  dout,
  output logic                  idle,
  output logic                  err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_HEADER = 2'd2;
  localparam logic [1:0] ST_DATA   = 2'd3;
  localparam logic [3:0] DLY_INIT  = 4'(START_DELAY);

  logic [WORD_WIDTH-1:0] mem [0:2*PKT_NUM_WORDS-1];
  logic [WORD_WIDTH-1:0] rd_word;

  logic [1:0] state_q, state_d;
  logic       wr_page_q, wr_page_d;
  logic       rd_page_q, rd_page_d;
  logic [1:0] full_cnt_q, full_cnt_d;
  logic [3:0] dly_cnt_q, dly_cnt_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic       wr_ready_q, wr_ready_d;
  logic       empty_q, empty_d;
  logic       dout_q, dout_d;
  logic       idle_q, idle_d;
  logic       err_q, err_d;
  logic       commit, rel_pg;

  always_comb begin
    // NOTE: every _d starts from its _q (or a safe constant) so no branch can infer a latch.
    state_d    = state_q;
    wr_page_d  = wr_page_q;
    rd_page_d  = rd_page_q;
    dly_cnt_d  = dly_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    dout_d     = 1'b0;
    err_d      = err_q;
    rel_pg     = 1'b0;
    commit     = wr_commit & wr_ready_q;
    rd_word    = mem[{rd_page_q, bit_cnt_q[7:4]}];

    if ((wr_en | wr_commit) & ~wr_ready_q) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rd_en) begin
          if (!empty_q) begin
            dly_cnt_d = DLY_INIT;
            state_d   = (START_DELAY == 0) ? ST_HEADER : ST_DELAY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        dly_cnt_d = dly_cnt_q - 4'd1;
        if (dly_cnt_q == 4'd1) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        dout_d    = 1'b1;
        bit_cnt_d = 8'd0;
        state_d   = ST_DATA;
      end
      default: begin
        dout_d    = rd_word[bit_cnt_q[3:0]];
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == 8'hFF) begin
          rel_pg    = 1'b1;
          rd_page_d = ~rd_page_q;
          state_d   = ST_IDLE;
        end
      end
    endcase

    if (rd_en && (state_q != ST_IDLE)) err_d = 1'b1;
    if (commit) wr_page_d = ~wr_page_q;

    // A commit and a release in the same cycle cancel; readiness follows the net count.
    full_cnt_d = full_cnt_q + {1'b0, commit} - {1'b0, rel_pg};
    wr_ready_d = (full_cnt_d < 2'd2);

    // empty only re-evaluates once the FSM has already settled back in idle.
    empty_d = 1'b1;
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) empty_d = (full_cnt_d == 2'd0);
    idle_d = (state_d == ST_IDLE) && (full_cnt_d == 2'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_page_q  <= 1'b0;
      rd_page_q  <= 1'b0;
      full_cnt_q <= 2'd0;
      dly_cnt_q  <= 4'd0;
      bit_cnt_q  <= 8'd0;
      wr_ready_q <= 1'b1;
      empty_q    <= 1'b1;
      dout_q     <= 1'b0;
      idle_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_page_q  <= wr_page_d;
      rd_page_q  <= rd_page_d;
      full_cnt_q <= full_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_ready_q <= wr_ready_d;
      empty_q    <= empty_d;
      dout_q     <= dout_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
    end
  end

  // NOTE: page RAM has no reset so it maps onto distributed RAM; stale data is never read
  // because a page is only shifted out after it has been committed.
  always_ff @(posedge CLK) begin
    if (wr_en && wr_ready_q) mem[{wr_page_q, wr_addr}] <= din;
  end

  assign wr_ready = wr_ready_q;
  assign empty    = empty_q;
  assign dout     = dout_q;
  assign idle     = idle_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcrypt_core_output.sv
// Directed bench for bcrypt_core_output: a START_DELAY=2 instance for the main scenarios
// and a START_DELAY=0 instance for the zero-delay header timing.
module tb_bcrypt_core_output;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic [3:0]  wr_addr;
  logic        wr_en, wr_commit, rd_en;
  logic        wr_en0, wr_commit0, rd_en0;
  logic        wr_ready, empty, dout, idle, err;
  logic        wr_ready0, empty0, dout0, idle0, err0;
  logic        sel;
  logic        obs_dout, obs_empty;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  assign obs_dout  = sel ? dout0  : dout;
  assign obs_empty = sel ? empty0 : empty;

  bcrypt_core_output #(.START_DELAY(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .din(din), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_commit(wr_commit), .wr_ready(wr_ready), .rd_en(rd_en), .empty(empty),
    .dout(dout), .idle(idle), .err(err)
  );

  bcrypt_core_output #(.START_DELAY(0)) dut0 (
    .CLK(CLK), .rst_n(rst_n), .din(din), .wr_addr(wr_addr), .wr_en(wr_en0),
    .wr_commit(wr_commit0), .wr_ready(wr_ready0), .rd_en(rd_en0), .empty(empty0),
    .dout(dout0), .idle(idle0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    {wr_en, wr_commit, rd_en, wr_en0, wr_commit0, rd_en0} = '0;
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic write_words(input int which, input logic [15:0] base, input logic or_idx);
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (which == 0) wr_en = 1'b1; else wr_en0 = 1'b1;
      wr_addr = k[3:0];
      din     = or_idx ? (base | 16'(k)) : base;
    end
    @(negedge CLK);
    wr_en  = 1'b0;
    wr_en0 = 1'b0;
  endtask

  task automatic do_commit(input int which);
    if (which == 0) wr_commit = 1'b1; else wr_commit0 = 1'b1;
    @(negedge CLK);
    wr_commit  = 1'b0;
    wr_commit0 = 1'b0;
  endtask

  task automatic write_pkt(input int which, input logic [15:0] base, input logic or_idx);
    write_words(which, base, or_idx);
    do_commit(which);
  endtask

  // Pulse rd_en, check header latency and the 256 LSB-first bits, optionally pulsing
  // wr_commit so that it lands on the last-bit (release) edge.
  task automatic read_pkt(input int which, input logic [15:0] base, input logic or_idx,
                          input logic commit_last, input logic exp_empty_after,
                          input string tag);
    int k;
    int exp_hdr;
    logic [15:0] w;
    sel     = (which != 0);
    exp_hdr = (which == 0) ? 3 : 1;
    @(negedge CLK);
    if (which == 0) rd_en = 1'b1; else rd_en0 = 1'b1;
    @(negedge CLK);
    rd_en  = 1'b0;
    rd_en0 = 1'b0;
    check($sformatf("%s_empty_busy", tag), obs_empty, 1);
    k = 0;
    while (obs_dout == 1'b0 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check($sformatf("%s_hdr_cycle", tag), k, exp_hdr);
    if (k >= 20) return;
    for (int wd = 0; wd < 16; wd++) begin
      w = '0;
      for (int b = 0; b < 16; b++) begin
        @(negedge CLK);
        w[b] = obs_dout;
        if (commit_last && wd == 15 && b == 14) begin
          if (which == 0) wr_commit = 1'b1; else wr_commit0 = 1'b1;
        end else begin
          wr_commit  = 1'b0;
          wr_commit0 = 1'b0;
        end
      end
      check($sformatf("%s_w%0d", tag, wd), w, or_idx ? (base | 16'(wd)) : base);
    end
    check($sformatf("%s_empty_last", tag), obs_empty, 1);
    @(negedge CLK);
    check($sformatf("%s_dout_after", tag), obs_dout, 0);
    check($sformatf("%s_empty_after", tag), obs_empty, exp_empty_after);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ones;
    int nonempty;
    rst_n = 1'b0;
    sel   = 1'b0;
    din   = '0;
    wr_addr = '0;
    {wr_en, wr_commit, rd_en, wr_en0, wr_commit0, rd_en0} = '0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_dout", dout, 0);
    check("rst_idle", idle, 1);
    check("rst_err", err, 0);

    // Single packet, words A500|k.
    write_pkt(0, 16'hA500, 1'b1);
    check("s1_empty_commit", empty, 0);
    check("s1_idle_commit", idle, 0);
    read_pkt(0, 16'hA500, 1'b1, 1'b0, 1'b1, "s1");
    check("s1_wr_ready", wr_ready, 1);
    check("s1_idle", idle, 1);
    check("s1_err", err, 0);

    // Two pages full, third commit rejected, back-to-back reads in order.
    do_reset();
    write_pkt(0, 16'h1111, 1'b0);
    write_pkt(0, 16'h2222, 1'b0);
    check("s2_wr_ready_full", wr_ready, 0);
    check("s2_err_before", err, 0);
    do_commit(0);
    check("s2_err_third", err, 1);
    check("s2_wr_ready_still", wr_ready, 0);
    read_pkt(0, 16'h1111, 1'b0, 1'b0, 1'b0, "s2a");
    read_pkt(0, 16'h2222, 1'b0, 1'b0, 1'b1, "s2b");
    check("s2_idle_end", idle, 1);

    // rd_en with nothing committed.
    do_reset();
    @(negedge CLK);
    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    ones = 0;
    nonempty = 0;
    repeat (300) begin
      @(negedge CLK);
      if (dout) ones++;
      if (!empty) nonempty++;
    end
    check("s3_no_header", ones, 0);
    check("s3_empty_stays", nonempty, 0);
    check("s3_err", err, 1);

    // Reset at bit 100 of an all-ones packet, then a clean transfer.
    do_reset();
    write_pkt(0, 16'hFFFF, 1'b0);
    @(negedge CLK);
    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    repeat (4 + 100) @(negedge CLK);
    check("s4_dout_pre", dout, 1);
    rst_n = 1'b0;
    #1;
    check("s4_dout_rst", dout, 0);
    check("s4_empty_rst", empty, 1);
    check("s4_wr_ready_rst", wr_ready, 1);
    check("s4_idle_rst", idle, 1);
    @(negedge CLK);
    rst_n = 1'b1;
    write_pkt(0, 16'h5A00, 1'b1);
    read_pkt(0, 16'h5A00, 1'b1, 1'b0, 1'b1, "s4");
    check("s4_err", err, 0);

    // Commit on the release edge with both pages full: rejected.
    do_reset();
    write_pkt(0, 16'h1111, 1'b0);
    write_pkt(0, 16'h2222, 1'b0);
    read_pkt(0, 16'h1111, 1'b0, 1'b1, 1'b0, "s5a");
    check("s5a_err", err, 1);
    check("s5a_wr_ready", wr_ready, 1);
    read_pkt(0, 16'h2222, 1'b0, 1'b0, 1'b1, "s5b");

    // Commit on the release edge with one page full: count stays at 1.
    do_reset();
    write_pkt(0, 16'h3333, 1'b0);
    write_words(0, 16'h4444, 1'b0);
    read_pkt(0, 16'h3333, 1'b0, 1'b1, 1'b0, "s5c");
    check("s5c_err", err, 0);
    check("s5c_wr_ready", wr_ready, 1);
    read_pkt(0, 16'h4444, 1'b0, 1'b0, 1'b1, "s5d");

    // Zero start delay instance.
    do_reset();
    write_pkt(1, 16'hA500, 1'b1);
    read_pkt(1, 16'hA500, 1'b1, 1'b0, 1'b1, "s6");
    check("s6_err", err0, 0);
    check("s6_idle", idle0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
